el2_lsu_addrchk_arb: RTL
========================

// Module: el2_lsu_addrchk_arb
// PURPOSE
//  Shares the LSU D-stage address-check port between core LSU, DMA and debug system-bus requesters.
//  Selects one request per cycle and computes end address from size.
//  Registers the winning packet into a 1-entry issue slot that holds under downstream stall.
//  Bounds DMA starvation with a saturating wait counter; sits directly in front of the address checker.
// PARAMETERS
//  STARVE_MAX  15  DMA wait cycles (4-bit, 0..15) before DMA overrides core; 0 = DMA always top priority
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   reset, asynchronous, active-high
//  core_req_valid      in   1   core LSU request
//  core_req_addr       in   32  core start address
//  core_req_size       in   2   0=byte 1=half 2=word (3 treated as word)
//  core_req_store      in   1   1=store 0=load
//  core_req_ready      out  1   core request accepted this cycle
//  dma_req_valid/_addr/_size/_store   in  1/32/2/1  DMA request, same encoding
//  dma_req_ready       out  1   DMA request accepted this cycle
//  dbg_req_valid/_addr/_size/_store   in  1/32/2/1  debug SB request, same encoding
//  dbg_req_ready       out  1   debug request accepted this cycle
//  chk_stall           in   1   downstream cannot take issue slot this cycle
//  chk_valid_d         out  1   issue slot valid
//  chk_start_addr_d    out  32  start address to checker
//  chk_end_addr_d      out  32  start + bytes - 1, modulo 2^32
//  chk_store_d         out  1   store flag
//  chk_dma_d           out  1   1 when source is DMA (checker suppresses faults)
//  chk_src_d           out  2   el2_lsu_arb_src_e of slot owner
// BEHAVIOUR
//  - Reset: chk_valid_d=0, all chk_* data=0, chk_src_d=SRC_NONE, starvation counter=0, all *_ready=0.
//  - accept = ~(chk_valid_d & chk_stall); *_ready is combinational, at most one high, only when accept.
//  - Priority when accept: DMA if dma_req_valid & cnt==STARVE_MAX; else core > dbg > DMA.
//  - Latency 1: request accepted in cycle N appears on chk_* in N+1.
//  - Slot: loads the winner when accept; clears chk_valid_d when accept and no request valid.
//    Holds all chk_* unchanged while chk_valid_d & chk_stall.
//  - End address: 32-bit add, wrap intentional (0xFFFF_FFFF word -> end 0x0000_0002); checker flags region cross.
//  - Starve counter: +1 (saturating at STARVE_MAX) each cycle dma_req_valid & ~dma_req_ready.
//    Cleared on dma_req_ready or ~dma_req_valid.
//  - Stall with pending DMA still counts; counter never exceeds STARVE_MAX.
//  - Simultaneous all-valid with cnt<STARVE_MAX: core granted, dbg and DMA wait, counter increments.
//  - Reset asserted mid-stall: slot dropped immediately (async), no request is replayed.
//  - Requesters hold valid/payload stable until ready; block never drops an accepted request.
// CONFIGURATION
//  - EL2_LSU_ARB_DBG_EN defined: debug requester participates as above.
//  - Not defined: dbg_* inputs ignored, dbg_req_ready tied 0; priority reduces to core > DMA plus starvation override.
//  - chk_src_d never equals SRC_DBG when not defined.
// STRUCTURE
//  - el2_pkg: typedef enum logic[1:0] el2_lsu_arb_src_e {SRC_NONE=0,SRC_CORE=1,SRC_DMA=2,SRC_DBG=3}.
//  - el2_pkg: typedef struct el2_lsu_arb_req_t {addr[31:0], size[1:0], store}.
//  - el2_pkg: function el2_lsu_size_bytes(size) returning 1/2/4.
//  - Sub-module el2_lsu_arb_starve_cnt: saturating 4-bit counter (inc, clr, sat flag).
//  - Top holds grant logic, end-address adder, issue-slot flops.
// TESTING
//  1. core word @0xF004_0000, no stall -> core_req_ready=1 cycle N; N+1 chk_end_addr_d=0xF004_0003, chk_src_d=SRC_CORE, chk_dma_d=0.
//  2. core and DMA valid continuously, STARVE_MAX=3 -> core wins 3 cycles, 4th cycle dma_req_ready=1, counter back to 0.
//  3. slot valid, chk_stall=1 for 5 cycles with new core request -> chk_* stable, core_req_ready=0, accepted in cycle stall drops.
//  4. DMA half @0xFFFF_FFFF -> chk_end_addr_d=0x0000_0000, chk_dma_d=1.
//  5. dbg+DMA valid, core idle, EL2_LSU_ARB_DBG_EN set -> dbg granted first; undefined -> DMA granted, dbg_req_ready never 1.
//  6. rst pulse while slot valid and stalled -> chk_valid_d=0 same cycle, counter=0, no grant while rst high.

Source files
------------

// File: rtl/el2_pkg.sv
// LSU address-check arbiter shared types: source ids, request bundle
// and access-size decode.
package el2_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CORE = 2'd1,
    SRC_DMA  = 2'd2,
    SRC_DBG  = 2'd3
  } el2_lsu_arb_src_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        store;
  } el2_lsu_arb_req_t;

  // size 3 is not a legal LSU size; it is treated as a word
  function automatic logic [2:0] el2_lsu_size_bytes(
    input logic [1:0] size
  );
    logic [2:0] b;
    case (size)
      2'd0:    b = 3'd1;
      2'd1:    b = 3'd2;
      default: b = 3'd4;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/el2_lsu_arb_starve_cnt.sv
// Saturating 4-bit DMA wait counter; sat flags that DMA must win
// the next arbitration.
module el2_lsu_arb_starve_cnt #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/el2_lsu_addrchk_arb.sv
// Core/DMA/debug arbiter feeding the LSU address checker issue slot.
// Debug requester is built in only with EL2_LSU_ARB_DBG_EN defined.
module el2_lsu_addrchk_arb
  import el2_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  input  logic [31:0] core_req_addr,
  input  logic [1:0]  core_req_size,
  input  logic        core_req_store,
  output logic        core_req_ready,
  input  logic        dma_req_valid,
  input  logic [31:0] dma_req_addr,
  input  logic [1:0]  dma_req_size,
  input  logic        dma_req_store,
  output logic        dma_req_ready,
  input  logic        dbg_req_valid,
  input  logic [31:0] dbg_req_addr,
  input  logic [1:0]  dbg_req_size,
  input  logic        dbg_req_store,
  output logic        dbg_req_ready,
  input  logic        chk_stall,
  output logic        chk_valid_d,
  output logic [31:0] chk_start_addr_d,
  output logic [31:0] chk_end_addr_d,
  output logic        chk_store_d,
  output logic        chk_dma_d,
  output logic [1:0]  chk_src_d
);

  el2_lsu_arb_req_t core_r, dma_r, dbg_r, win;
  el2_lsu_arb_src_e src_w;
  logic             dbg_v;
  logic             accept, dma_sat, dma_ovr;
  logic             g_core, g_dma, g_dbg;

  logic             valid_q, valid_d;
  logic [31:0]      start_q, start_d;
  logic [31:0]      end_q, end_d;
  logic             store_q, store_d;
  logic             dma_q, dma_d;
  el2_lsu_arb_src_e src_q, src_d;

  assign core_r = '{core_req_addr, core_req_size, core_req_store};
  assign dma_r  = '{dma_req_addr, dma_req_size, dma_req_store};

`ifdef EL2_LSU_ARB_DBG_EN
  assign dbg_v = dbg_req_valid;
  assign dbg_r = '{dbg_req_addr, dbg_req_size, dbg_req_store};
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req_valid, dbg_req_addr,
                        dbg_req_size, dbg_req_store};
  assign dbg_v = 1'b0;
  assign dbg_r = '0;
`endif

  el2_lsu_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (dma_req_valid & ~g_dma),
    .clr (g_dma | ~dma_req_valid),
    .sat (dma_sat)
  );

  // no grants while the slot is stalled or reset is held
  assign accept  = ~(valid_q & chk_stall) & ~rst;
  assign dma_ovr = dma_req_valid & dma_sat;
  assign g_core  = accept & core_req_valid & ~dma_ovr;
  assign g_dbg   = accept & dbg_v & ~core_req_valid & ~dma_ovr;
  assign g_dma   = accept & dma_req_valid &
                   (dma_ovr | (~core_req_valid & ~dbg_v));

  assign core_req_ready = g_core;
  assign dma_req_ready  = g_dma;
  assign dbg_req_ready  = g_dbg;

  always_comb begin
    win   = '0;
    src_w = SRC_NONE;
    unique case (1'b1)
      g_core: begin
        win   = core_r;
        src_w = SRC_CORE;
      end
      g_dbg: begin
        win   = dbg_r;
        src_w = SRC_DBG;
      end
      g_dma: begin
        win   = dma_r;
        src_w = SRC_DMA;
      end
      default: ;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    start_d = start_q;
    end_d   = end_q;
    store_d = store_q;
    dma_d   = dma_q;
    src_d   = src_q;
    if (accept) begin
      valid_d = (src_w != SRC_NONE);
      src_d   = src_w;
      dma_d   = (src_w == SRC_DMA);
      if (src_w != SRC_NONE) begin
        start_d = win.addr;
        // wraps past 2^32 on purpose; checker flags the crossing
        end_d   = win.addr
                + 32'(el2_lsu_size_bytes(win.size))
                - 32'd1;
        store_d = win.store;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      start_q <= 32'd0;
      end_q   <= 32'd0;
      store_q <= 1'b0;
      dma_q   <= 1'b0;
      src_q   <= SRC_NONE;
    end else begin
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
      store_q <= store_d;
      dma_q   <= dma_d;
      src_q   <= src_d;
    end
  end

  assign chk_valid_d      = valid_q;
  assign chk_start_addr_d = start_q;
  assign chk_end_addr_d   = end_q;
  assign chk_store_d      = store_q;
  assign chk_dma_d        = dma_q;
  assign chk_src_d        = src_q;

endmodule
